// File: rtl/dkong_bus_arbiter.sv
// Hold responder between the sprite DMA (HRQ/HLDA) and the Z80 (BUSRQn/BUSAKn).
// Adds bus turnaround, a maximum hold time and a minimum CPU-ownership gap.
module dkong_bus_arbiter #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned MAX_HOLD   = 2048,
  parameter int unsigned MIN_GAP    = 4,
  parameter int unsigned CNT_W      = 12
) (
  input  logic I_CLK,
  input  logic I_RST,
  input  logic I_CLK_EN,
  input  logic I_HRQ,
  input  logic I_CPU_BUSAKn,
  output logic O_CPU_BUSRQn,
  output logic O_HLDA,
  output logic O_BUS_SEL,
  output logic O_ABORT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETTLE,
    S_GRANT,
    S_RELEASE,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(MIN_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             armed;

  // One counter serves SETTLE, GRANT and GAP; it is cleared on entry to each.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state        <= S_IDLE;
      cnt          <= '0;
      armed        <= 1'b1;
      O_CPU_BUSRQn <= 1'b1;
      O_HLDA       <= 1'b0;
      O_BUS_SEL    <= 1'b0;
      O_ABORT      <= 1'b0;
    end else if (I_CLK_EN) begin
      O_ABORT <= 1'b0;
      if (!I_HRQ) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          if (I_HRQ && armed) begin
            state        <= S_REQ;
            O_CPU_BUSRQn <= 1'b0;
          end
        end

        S_REQ: begin
          if (!I_HRQ) begin
            state        <= S_IDLE;
            O_CPU_BUSRQn <= 1'b1;
          end else if (!I_CPU_BUSAKn) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end
        end

        S_SETTLE: begin
          cnt <= cnt + CNT_ONE;
          // A CPU that lets go of BUSAKn early forfeits the grant.
          if (!I_HRQ || I_CPU_BUSAKn) begin
            state <= S_RELEASE;
          end else if (cnt == SETTLE_LAST) begin
            state     <= S_GRANT;
            O_HLDA    <= 1'b1;
            O_BUS_SEL <= 1'b1;
            cnt       <= '0;
          end
        end

        S_GRANT: begin
          cnt <= cnt + CNT_ONE;
          if (!I_HRQ || I_CPU_BUSAKn) begin
            state     <= S_RELEASE;
            O_HLDA    <= 1'b0;
            O_BUS_SEL <= 1'b0;
          end else if (cnt == HOLD_LAST) begin
            state     <= S_RELEASE;
            O_HLDA    <= 1'b0;
            O_BUS_SEL <= 1'b0;
            O_ABORT   <= 1'b1;
            armed     <= 1'b0;
          end
        end

        // Mux has already swung back; hold BUSRQn one more cycle before the CPU resumes.
        S_RELEASE: begin
          state        <= S_GAP;
          O_CPU_BUSRQn <= 1'b1;
          cnt          <= '0;
        end

        S_GAP: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == GAP_LAST) state <= S_IDLE;
        end

        default: begin
          state        <= S_IDLE;
          cnt          <= '0;
          O_CPU_BUSRQn <= 1'b1;
          O_HLDA       <= 1'b0;
          O_BUS_SEL    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dkong_bus_arbiter.sv
// Bench for dkong_bus_arbiter: phase/age reference model checked every cycle,
// plus directed scenarios with hand-computed latencies.
module tb_dkong_bus_arbiter;

  localparam int SETTLE_CYC = 2;
  localparam int MAX_HOLD   = 2048;
  localparam int MIN_GAP    = 4;

  localparam int P_IDLE  = 0;
  localparam int P_ASK   = 1;
  localparam int P_TURN  = 2;
  localparam int P_OWN   = 3;
  localparam int P_BACK  = 4;
  localparam int P_REST  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic hrq = 1'b0;
  logic busak_n = 1'b1;
  logic busrq_n, hlda, bus_sel, abort;

  int n_pass = 0;
  int n_total = 0;
  int abort_seen = 0;

  dkong_bus_arbiter #(
    .SETTLE_CYC(SETTLE_CYC), .MAX_HOLD(MAX_HOLD), .MIN_GAP(MIN_GAP), .CNT_W(12)
  ) dut (
    .I_CLK(clk), .I_RST(rst), .I_CLK_EN(en), .I_HRQ(hrq), .I_CPU_BUSAKn(busak_n),
    .O_CPU_BUSRQn(busrq_n), .O_HLDA(hlda), .O_BUS_SEL(bus_sel), .O_ABORT(abort)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: which phase the bus handshake is in and how many enabled
  // cycles (1-based) it has spent there.
  int m_ph, m_age;
  bit m_armed, m_abort;

  function automatic void model_next(input int ph, input int age, input bit armed,
                                     input bit q, input bit ak_n,
                                     output int nph, output int nage,
                                     output bit narmed, output bit nabort);
    nph = ph; nage = age + 1; narmed = armed | !q; nabort = 1'b0;
    case (ph)
      P_IDLE: if (q && armed) begin nph = P_ASK; nage = 1; end
      P_ASK: begin
        if (!q) begin nph = P_IDLE; nage = 1; end
        else if (!ak_n) begin nph = P_TURN; nage = 1; end
      end
      P_TURN: begin
        if (!q || ak_n) begin nph = P_BACK; nage = 1; end
        else if (age == SETTLE_CYC) begin nph = P_OWN; nage = 1; end
      end
      P_OWN: begin
        if (!q || ak_n) begin nph = P_BACK; nage = 1; end
        else if (age == MAX_HOLD) begin
          nph = P_BACK; nage = 1; nabort = 1'b1; narmed = 1'b0;
        end
      end
      P_BACK: begin nph = P_REST; nage = 1; end
      default: if (age == MIN_GAP) begin nph = P_IDLE; nage = 1; end
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    int nph, nage;
    bit narm, nab;
    if (rst) begin
      m_ph <= P_IDLE; m_age <= 1; m_armed <= 1'b1; m_abort <= 1'b0;
    end else if (en) begin
      model_next(m_ph, m_age, m_armed, hrq, busak_n, nph, nage, narm, nab);
      m_ph <= nph; m_age <= nage; m_armed <= narm; m_abort <= nab;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit cpu_off_bus;
    cpu_off_bus = (m_ph == P_ASK) || (m_ph == P_TURN) || (m_ph == P_OWN) || (m_ph == P_BACK);
    chk("busrq_n", int'(busrq_n), int'(!cpu_off_bus));
    chk("hlda", int'(hlda), int'(m_ph == P_OWN));
    chk("bus_sel", int'(bus_sel), int'(m_ph == P_OWN));
    chk("abort", int'(abort), int'(m_abort));
    if (abort) abort_seen++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_hlda(input string name);
    int n;
    n = 0;
    while (!hlda && n < 20) begin step(1); n++; end
    chk(name, int'(hlda), 1);
  endtask

  initial begin
    int n, cyc, low_cnt;

    // Reset state
    step(3);
    chk("rst_busrq_n", int'(busrq_n), 1);
    chk("rst_hlda", int'(hlda), 0);
    chk("rst_bus_sel", int'(bus_sel), 0);
    chk("rst_abort", int'(abort), 0);
    rst = 1'b0;
    step(2);

    // 1: basic grant, BUSAKn 3 cycles after BUSRQn
    hrq = 1'b1;
    step(1);
    chk("t1_busrq_low", int'(busrq_n), 0);
    step(2);
    busak_n = 1'b0;
    step(1); chk("t1_hlda_e1", int'(hlda), 0);
    step(1); chk("t1_hlda_e2", int'(hlda), 0);
    step(1); chk("t1_hlda_e3", int'(hlda), 1);
    step(5);
    hrq = 1'b0;
    step(1);
    chk("t1_hlda_drop", int'(hlda), 0);
    chk("t1_busrq_hold", int'(busrq_n), 0);
    step(1);
    chk("t1_busrq_rel", int'(busrq_n), 1);
    busak_n = 1'b1;
    step(6);

    // 4: HRQ withdrawn while waiting for BUSAKn
    hrq = 1'b1;
    step(1);
    chk("t4_busrq_low", int'(busrq_n), 0);
    hrq = 1'b0;
    step(1);
    chk("t4_busrq_high", int'(busrq_n), 1);
    chk("t4_hlda", int'(hlda), 0);
    step(3);

    // 2: full sprite DMA, then immediate re-request is held off by the gap
    hrq = 1'b1;
    step(1);
    busak_n = 1'b0;
    wait_hlda("t2_grant");
    step(1535);
    chk("t2_hlda_still", int'(hlda), 1);
    hrq = 1'b0;
    step(1);
    chk("t2_hlda_drop", int'(hlda), 0);
    hrq = 1'b1;
    step(1);
    chk("t2_busrq_rel", int'(busrq_n), 1);
    busak_n = 1'b1;
    n = 0;
    do begin step(1); n++; end while (busrq_n && n < 20);
    chk("t2_gap_edges", n, 5);
    chk("t2_no_abort", abort_seen, 0);

    // 5: clock enable low mid-grant freezes everything
    busak_n = 1'b0;
    wait_hlda("t5_grant");
    step(3);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t5_frozen_hlda", int'(hlda), 1);
      chk("t5_frozen_busrq", int'(busrq_n), 0);
    end
    en = 1'b1;
    step(2);
    hrq = 1'b0;
    step(1);
    chk("t5_hlda_drop", int'(hlda), 0);
    step(1);
    chk("t5_busrq_rel", int'(busrq_n), 1);
    busak_n = 1'b1;
    step(6);

    // 3: hold past MAX_HOLD forces a release and disarms
    hrq = 1'b1;
    step(1);
    busak_n = 1'b0;
    wait_hlda("t3_grant");
    cyc = 1;
    while (hlda && cyc < 3000) begin step(1); if (hlda) cyc++; end
    chk("t3_hold_cycles", cyc, 2048);
    chk("t3_abort_pulse", int'(abort), 1);
    busak_n = 1'b1;
    step(1);
    chk("t3_abort_once", int'(abort), 0);
    low_cnt = 0;
    for (int i = 0; i < 900; i++) begin
      step(1);
      if (!busrq_n) low_cnt++;
    end
    chk("t3_disarmed", low_cnt, 0);
    hrq = 1'b0;
    step(1);
    hrq = 1'b1;
    step(1);
    chk("t3_rearmed", int'(busrq_n), 0);
    hrq = 1'b0;
    step(3);

    // 6: asynchronous reset mid-grant
    hrq = 1'b1;
    step(1);
    busak_n = 1'b0;
    wait_hlda("t6_grant");
    step(5);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_hlda", int'(hlda), 0);
    chk("t6_async_sel", int'(bus_sel), 0);
    chk("t6_async_busrq", int'(busrq_n), 1);
    hrq = 1'b0;
    busak_n = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    hrq = 1'b1;
    step(1);
    chk("t6_after_rst_req", int'(busrq_n), 0);
    hrq = 1'b0;
    step(3);

    chk("total_aborts", abort_seen, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
